// File: rtl/stage_sequencer.sv
// Stage controller stepping the datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; strobes decode from state in the same cycle.
// 5 cycles per instruction (2 for a NOP); MEMORY stalls on Mem_Ready and traps to a sticky FAULT after MEM_TIMEOUT wait cycles.
module stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset_L,
    input  logic        Run,
    input  logic        Halt_Req,
    input  logic        NOP_FLAG,
    input  logic        Mem_Access,
    input  logic        WillWriteTo_Memory_H_RF_L,
    input  logic        Mem_Ready,
    output logic [2:0]  Stage,
    output logic        ROM1_Read,
    output logic        IR_Enable,
    output logic        PC_Enable,
    output logic        RA_Enable,
    output logic        RB_Enable,
    output logic        RZ_Enable,
    output logic        RM_Enable,
    output logic        RY_Enable,
    output logic        RF_WRITE,
    output logic        RAM1_Write_L,
    output logic        Busy,
    output logic        Fault,
    output logic [15:0] Instr_Retired
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd7
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_nxt;
    logic [7:0]  w_wait_inc;
    logic [15:0] r_retired;
    logic        w_retire;
    state_t      w_boundary;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
            r_retired  <= 16'd0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign w_wait_inc = r_wait_cnt + 8'd1;
    assign w_boundary = Halt_Req ? ST_IDLE : ST_FETCH;

    always_comb begin
        w_next       = r_state;
        w_wait_nxt   = r_wait_cnt;
        w_retire     = 1'b0;
        ROM1_Read    = 1'b0;
        IR_Enable    = 1'b0;
        PC_Enable    = 1'b0;
        RA_Enable    = 1'b0;
        RB_Enable    = 1'b0;
        RZ_Enable    = 1'b0;
        RM_Enable    = 1'b0;
        RY_Enable    = 1'b0;
        RF_WRITE     = 1'b0;
        RAM1_Write_L = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (Run) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ROM1_Read = 1'b1;
                IR_Enable = 1'b1;
                PC_Enable = 1'b1;
                w_next    = ST_DECODE;
            end
            ST_DECODE: begin
                if (NOP_FLAG) begin
                    w_retire = 1'b1;
                    w_next   = w_boundary;
                end else begin
                    RA_Enable = 1'b1;
                    RB_Enable = 1'b1;
                    w_next    = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                RZ_Enable = 1'b1;
                w_next    = ST_MEMORY;
            end
            ST_MEMORY: begin
                if (!Mem_Access) begin
                    RM_Enable  = 1'b1;
                    w_wait_nxt = 8'd0;
                    w_next     = ST_WRITEBACK;
                end else begin
                    RAM1_Write_L = ~WillWriteTo_Memory_H_RF_L;
                    if (Mem_Ready) begin
                        // Completion wins even in the cycle that would otherwise time out.
                        RM_Enable  = 1'b1;
                        w_wait_nxt = 8'd0;
                        w_next     = ST_WRITEBACK;
                    end else begin
                        w_wait_nxt = w_wait_inc;
                        if (w_wait_inc == TIMEOUT_CNT) begin
                            w_next = ST_FAULT;
                        end
                    end
                end
            end
            ST_WRITEBACK: begin
                RY_Enable = 1'b1;
                RF_WRITE  = ~WillWriteTo_Memory_H_RF_L;
                w_retire  = 1'b1;
                w_next    = w_boundary;
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: begin
                w_next     = ST_IDLE;
                w_wait_nxt = 8'd0;
            end
        endcase
    end

    assign Stage         = r_state;
    assign Busy          = (r_state != ST_IDLE) && (r_state != ST_FAULT);
    assign Fault         = (r_state == ST_FAULT);
    assign Instr_Retired = r_retired;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed cycle table, corner sequences, and a randomized instruction-level model.
`timescale 1ns/1ps
module tb_stage_sequencer;

    localparam int T = 4;

    logic        Clock = 1'b0;
    logic        Reset_L = 1'b0;
    logic        Run = 1'b0;
    logic        Halt_Req = 1'b0;
    logic        NOP_FLAG = 1'b0;
    logic        Mem_Access = 1'b0;
    logic        WillWriteTo_Memory_H_RF_L = 1'b0;
    logic        Mem_Ready = 1'b0;
    logic [2:0]  Stage;
    logic        ROM1_Read, IR_Enable, PC_Enable, RA_Enable, RB_Enable;
    logic        RZ_Enable, RM_Enable, RY_Enable, RF_WRITE, RAM1_Write_L, Busy, Fault;
    logic [15:0] Instr_Retired;

    always #5 Clock = ~Clock;

    stage_sequencer #(.MEM_TIMEOUT(T)) dut (
        .Clock(Clock), .Reset_L(Reset_L), .Run(Run), .Halt_Req(Halt_Req),
        .NOP_FLAG(NOP_FLAG), .Mem_Access(Mem_Access),
        .WillWriteTo_Memory_H_RF_L(WillWriteTo_Memory_H_RF_L), .Mem_Ready(Mem_Ready),
        .Stage(Stage), .ROM1_Read(ROM1_Read), .IR_Enable(IR_Enable), .PC_Enable(PC_Enable),
        .RA_Enable(RA_Enable), .RB_Enable(RB_Enable), .RZ_Enable(RZ_Enable),
        .RM_Enable(RM_Enable), .RY_Enable(RY_Enable), .RF_WRITE(RF_WRITE),
        .RAM1_Write_L(RAM1_Write_L), .Busy(Busy), .Fault(Fault), .Instr_Retired(Instr_Retired)
    );

    // Output vector order: ROM1 IR PC RA RB RZ RM RY RF WR_L Busy Fault
    wire [11:0] w_obs = {ROM1_Read, IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable,
                         RM_Enable, RY_Enable, RF_WRITE, RAM1_Write_L, Busy, Fault};

    localparam logic [11:0] O_IDLE  = 12'h004;
    localparam logic [11:0] O_FETCH = 12'hE06;
    localparam logic [11:0] O_DEC   = 12'h186;
    localparam logic [11:0] O_DECN  = 12'h006;
    localparam logic [11:0] O_EXEC  = 12'h046;
    localparam logic [11:0] O_MEM   = 12'h026;
    localparam logic [11:0] O_STW   = 12'h002;
    localparam logic [11:0] O_STD   = 12'h022;
    localparam logic [11:0] O_LDW   = 12'h006;
    localparam logic [11:0] O_WBR   = 12'h01E;
    localparam logic [11:0] O_WBS   = 12'h016;
    localparam logic [11:0] O_FLT   = 12'h005;

    typedef struct {
        logic rst, run, halt, nop, mem, wr, rdy;
        logic [2:0]  st;
        logic [11:0] o;
        logic [15:0] r;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;
    logic [15:0] m_ret;
    bit m_idle;

    function automatic vec_t mkv(logic rst, logic run, logic halt, logic nop, logic mem, logic wr,
                                 logic rdy, logic [2:0] st, logic [11:0] o, logic [15:0] r);
        vec_t v;
        v.rst = rst; v.run = run; v.halt = halt; v.nop = nop; v.mem = mem; v.wr = wr; v.rdy = rdy;
        v.st = st; v.o = o; v.r = r;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic run, input logic halt, input logic nop,
                       input logic mem, input logic wr, input logic rdy,
                       input logic [2:0] es, input logic [11:0] eo, input logic [15:0] er,
                       input string tag);
        @(posedge Clock);
        #1;
        Reset_L = rst; Run = run; Halt_Req = halt; NOP_FLAG = nop;
        Mem_Access = mem; WillWriteTo_Memory_H_RF_L = wr; Mem_Ready = rdy;
        #3;
        chk({tag, " stage"}, 16'(Stage), 16'(es));
        chk({tag, " strobes"}, 16'(w_obs), 16'(eo));
        chk({tag, " retired"}, Instr_Retired, er);
    endtask

    // Instruction-level reference: expands one instruction into its expected cycle sequence.
    task automatic rnd_instr();
        bit nop, mem, wr, h, r;
        int dly, idle_n;
        nop = ($urandom_range(0, 2) == 0);
        mem = rb();
        wr  = rb();
        dly = $urandom_range(0, T - 1);
        idle_n = 0;
        while (m_idle) begin
            r = (idle_n >= 6) ? 1'b1 : rb();
            cyc(1, r, rb(), rb(), rb(), rb(), rb(), 3'd0, O_IDLE, m_ret, "rnd idle");
            idle_n++;
            if (r) m_idle = 1'b0;
        end
        cyc(1, rb(), rb(), rb(), rb(), rb(), rb(), 3'd1, O_FETCH, m_ret, "rnd fetch");
        if (nop) begin
            h = ($urandom_range(0, 3) == 0);
            cyc(1, rb(), h, 1'b1, rb(), rb(), rb(), 3'd2, O_DECN, m_ret, "rnd decode nop");
            m_ret  = m_ret + 16'd1;
            m_idle = h;
            return;
        end
        cyc(1, rb(), rb(), 1'b0, mem, wr, rb(), 3'd2, O_DEC, m_ret, "rnd decode");
        cyc(1, rb(), rb(), 1'b0, mem, wr, rb(), 3'd3, O_EXEC, m_ret, "rnd execute");
        if (!mem) begin
            cyc(1, rb(), rb(), 1'b0, 1'b0, wr, rb(), 3'd4, O_MEM, m_ret, "rnd memory alu");
        end else begin
            for (int i = 0; i <= dly; i++) begin
                cyc(1, rb(), rb(), 1'b0, 1'b1, wr, logic'(i == dly), 3'd4,
                    wr ? ((i == dly) ? O_STD : O_STW) : ((i == dly) ? O_MEM : O_LDW),
                    m_ret, "rnd memory wait");
            end
        end
        h = ($urandom_range(0, 3) == 0);
        cyc(1, rb(), h, 1'b0, mem, wr, rb(), 3'd5, wr ? O_WBS : O_WBR, m_ret, "rnd writeback");
        m_ret  = m_ret + 16'd1;
        m_idle = h;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rst run hlt nop mem wr rdy  st    out     ret
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd0));
        tbl.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 3'd1, O_FETCH, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1, 3'd2, O_DEC, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1, 3'd3, O_EXEC, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 1, 3'd4, O_MEM, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 3'd5, O_WBR, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 1, 0, 0, 0, 3'd1, O_FETCH, 16'd1));
        tbl.push_back(mkv(1, 0, 0, 1, 0, 0, 0, 3'd2, O_DECN, 16'd1));
        tbl.push_back(mkv(1, 0, 0, 1, 0, 0, 0, 3'd1, O_FETCH, 16'd2));
        tbl.push_back(mkv(1, 0, 0, 1, 0, 0, 0, 3'd2, O_DECN, 16'd2));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd1, O_FETCH, 16'd3));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd2, O_DEC, 16'd3));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd3, O_EXEC, 16'd3));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd4, O_STW, 16'd3));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd4, O_STW, 16'd3));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 1, 3'd4, O_STD, 16'd3));
        tbl.push_back(mkv(1, 0, 1, 0, 1, 1, 0, 3'd5, O_WBS, 16'd3));
        tbl.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd4));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd4));
        tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd4));
        tbl.push_back(mkv(1, 1, 1, 1, 0, 0, 0, 3'd1, O_FETCH, 16'd4));
        tbl.push_back(mkv(1, 1, 1, 1, 0, 0, 0, 3'd2, O_DECN, 16'd4));
        tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd5));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 3'd1, O_FETCH, 16'd5));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 3'd2, O_DEC, 16'd5));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 3'd3, O_EXEC, 16'd5));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 3'd4, O_LDW, 16'd5));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 3'd4, O_LDW, 16'd5));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 3'd4, O_LDW, 16'd5));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 1, 3'd4, O_MEM, 16'd5));
        tbl.push_back(mkv(1, 0, 1, 0, 1, 0, 0, 3'd5, O_WBR, 16'd5));
        tbl.push_back(mkv(1, 1, 0, 0, 1, 1, 0, 3'd0, O_IDLE, 16'd6));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd1, O_FETCH, 16'd6));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd2, O_DEC, 16'd6));
        tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd3, O_EXEC, 16'd6));
        for (int i = 0; i < T; i++) begin
            tbl.push_back(mkv(1, 0, 0, 0, 1, 1, 0, 3'd4, O_STW, 16'd6));
        end
        tbl.push_back(mkv(1, 1, 0, 0, 1, 1, 0, 3'd7, O_FLT, 16'd6));
        tbl.push_back(mkv(1, 1, 0, 0, 1, 1, 1, 3'd7, O_FLT, 16'd6));
        tbl.push_back(mkv(0, 1, 0, 0, 1, 1, 0, 3'd0, O_IDLE, 16'd0));
        tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd0));

        #2;
        chk("reset stage", 16'(Stage), 16'd0);
        chk("reset strobes", 16'(w_obs), 16'(O_IDLE));
        chk("reset retired", Instr_Retired, 16'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].run, tbl[i].halt, tbl[i].nop, tbl[i].mem, tbl[i].wr, tbl[i].rdy,
                tbl[i].st, tbl[i].o, tbl[i].r, $sformatf("table[%0d]", i));
        end

        // Retire counter wrap from 0xFFFF.
        force dut.r_retired = 16'hFFFF;
        #2;
        release dut.r_retired;
        cyc(1, 1, 0, 1, 0, 0, 0, 3'd0, O_IDLE, 16'hFFFF, "wrap idle");
        cyc(1, 0, 0, 1, 0, 0, 0, 3'd1, O_FETCH, 16'hFFFF, "wrap fetch");
        cyc(1, 0, 1, 1, 0, 0, 0, 3'd2, O_DECN, 16'hFFFF, "wrap decode");
        cyc(1, 0, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'h0000, "wrap result");

        // Asynchronous reset in the middle of a store wait.
        cyc(1, 1, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd0, "mid idle");
        cyc(1, 0, 0, 1, 0, 0, 0, 3'd1, O_FETCH, 16'd0, "mid fetch0");
        cyc(1, 0, 0, 1, 0, 0, 0, 3'd2, O_DECN, 16'd0, "mid nop");
        cyc(1, 0, 0, 0, 1, 1, 0, 3'd1, O_FETCH, 16'd1, "mid fetch1");
        cyc(1, 0, 0, 0, 1, 1, 0, 3'd2, O_DEC, 16'd1, "mid decode");
        cyc(1, 0, 0, 0, 1, 1, 0, 3'd3, O_EXEC, 16'd1, "mid execute");
        cyc(1, 0, 0, 0, 1, 1, 0, 3'd4, O_STW, 16'd1, "mid memory");
        #1;
        Reset_L = 1'b0;
        #1;
        chk("async reset write_l", 16'(RAM1_Write_L), 16'd1);
        chk("async reset stage", 16'(Stage), 16'd0);
        chk("async reset strobes", 16'(w_obs), 16'(O_IDLE));
        chk("async reset retired", Instr_Retired, 16'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 3'd0, O_IDLE, 16'd0, "post reset");

        m_ret  = 16'd0;
        m_idle = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rnd_instr();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
